// File: rtl/lebug_trace_pkg.sv
// Shared types and default sizing for the delta trace-buffer sequencer.
package lebug_trace_pkg;

  localparam int DEF_N          = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TB_SIZE    = 16;
  localparam int TB_PTR_W       = $clog2(DEF_TB_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    READ    = 2'd3
  } tb_state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] [DEF_N-1:0] tb_vec_t;

endpackage

// File: rtl/delta_tb_sequencer_if.sv
// Readout stream of the trace buffer: valid/ready handshake plus entry payload.
interface delta_tb_sequencer_if #(
  parameter int VEC_W = 256
) ();
  logic             rd_valid;
  logic             rd_ready;
  logic [VEC_W-1:0] rd_vector;
  logic             rd_comp;
  logic             rd_last;

  modport master (output rd_valid, output rd_vector, output rd_comp, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_vector, input rd_comp, input rd_last, output rd_ready);
endinterface

// File: rtl/delta_tb_ram.sv
// Trace buffer storage: one write port, one registered read port, no control logic.
module delta_tb_ram
  import lebug_trace_pkg::*;
#(
  parameter int DEPTH = DEF_TB_SIZE,
  parameter int WIDTH = DEF_N * DEF_DATA_WIDTH + 1,
  parameter int AW    = TB_PTR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read of the addressed entry every cycle.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/delta_tb_sequencer_chk.sv
// Protocol checker: an overwrite beat (inc=0) must never arrive before the first slot exists.
module delta_tb_sequencer_chk (
  input logic clk,
  input logic rst,
  input logic beat,
  input logic inc,
  input logic started
);

  // Flag overwrite beats that target an empty buffer; such beats are dropped by the sequencer.
  a_no_write_when_empty: assert property (@(posedge clk) disable iff (rst) !(beat && !inc && !started))
    else $error("delta_tb_sequencer: overwrite beat into empty trace buffer dropped");

endmodule

// File: rtl/delta_tb_sequencer.sv
// Capture/readout controller between the delta compressor and the trace buffer RAM.
// Optional build macro DELTA_TB_STOP_ON_FULL_EN: a full buffer ends capture with an
// automatic dump instead of wrapping over the oldest entry.
module delta_tb_sequencer
  import lebug_trace_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TB_SIZE    = DEF_TB_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        stop,
  input  logic                        dump,
  output logic                        comp_tracing,
  input  logic                        comp_valid,
  input  logic [N*DATA_WIDTH-1:0]     comp_vector,
  input  logic                        comp_is_comp,
  input  logic                        comp_inc_ptr,
  delta_tb_sequencer_if.master        rd,
  output logic [$clog2(TB_SIZE):0]    entries,
  output logic                        busy
);

  localparam int VEC_W = N * DATA_WIDTH;
  localparam int AW    = $clog2(TB_SIZE);
  localparam int EW    = AW + 1;
  localparam logic [EW-1:0] ENT_FULL = EW'(TB_SIZE);
`ifdef DELTA_TB_STOP_ON_FULL_EN
  localparam logic STOP_ON_FULL = 1'b1;
`else
  localparam logic STOP_ON_FULL = 1'b0;
`endif

  tb_state_t      state_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_addr_r;
  logic [EW-1:0]  entries_r;
  logic [EW-1:0]  rd_left_r;
  logic           started_r;
  logic           wrapped_r;
  logic           dump_req_r;
  logic           tracing_r;
  logic           busy_r;
  logic           rd_valid_r;
  logic           rd_last_r;

  logic           beat_s;
  logic           first_wr_s;
  logic           adv_wr_s;
  logic           over_wr_s;
  logic           full_hit_s;
  logic           stop_full_s;
  logic           wr_en_s;
  logic [AW-1:0]  wr_addr_s;
  logic [AW-1:0]  wr_ptr_inc_s;
  logic [AW-1:0]  rd_start_s;
  logic [AW-1:0]  ram_raddr_s;
  logic           rd_hs_s;
  logic [VEC_W:0] ram_rdata_s;

  // Classify a compressor beat: first slot, advance, overwrite, dropped-on-full or dropped-empty.
  always_comb begin
    stop_full_s  = STOP_ON_FULL && (entries_r == ENT_FULL);
    beat_s       = ((state_r == CAPTURE) || (state_r == DRAIN)) && comp_valid;
    wr_ptr_inc_s = wr_ptr_r + AW'(1);
    first_wr_s   = 1'b0;
    adv_wr_s     = 1'b0;
    over_wr_s    = 1'b0;
    full_hit_s   = 1'b0;
    if (beat_s) begin
      if (comp_inc_ptr) begin
        if (!started_r) begin
          first_wr_s = 1'b1;
        end else if (stop_full_s) begin
          full_hit_s = 1'b1;
        end else begin
          adv_wr_s = 1'b1;
        end
      end else begin
        over_wr_s = started_r;
      end
    end else begin
      over_wr_s = 1'b0;
    end
    wr_en_s = first_wr_s | adv_wr_s | over_wr_s;
    if (first_wr_s) begin
      wr_addr_s = {AW{1'b0}};
    end else if (adv_wr_s) begin
      wr_addr_s = wr_ptr_inc_s;
    end else begin
      wr_addr_s = wr_ptr_r;
    end
  end

  // Read address: oldest entry on the first READ cycle, then step past each accepted entry.
  always_comb begin
    rd_hs_s = rd_valid_r && rd.rd_ready;
    if (wrapped_r) begin
      rd_start_s = wr_ptr_inc_s;
    end else begin
      rd_start_s = {AW{1'b0}};
    end
    if ((state_r == READ) && !rd_valid_r) begin
      ram_raddr_s = rd_start_s;
    end else if (rd_hs_s) begin
      ram_raddr_s = rd_addr_r + AW'(1);
    end else begin
      ram_raddr_s = rd_addr_r;
    end
  end

  // Control FSM with buffer bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_addr_r  <= {AW{1'b0}};
      entries_r  <= {EW{1'b0}};
      rd_left_r  <= {EW{1'b0}};
      started_r  <= 1'b0;
      wrapped_r  <= 1'b0;
      dump_req_r <= 1'b0;
      tracing_r  <= 1'b1;
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      if (first_wr_s) begin
        started_r <= 1'b1;
        entries_r <= EW'(1);
        wr_ptr_r  <= {AW{1'b0}};
      end else if (adv_wr_s) begin
        wr_ptr_r <= wr_ptr_inc_s;
        if (entries_r != ENT_FULL) begin
          entries_r <= entries_r + EW'(1);
        end
        if (!STOP_ON_FULL && (entries_r == (ENT_FULL - EW'(1)))) begin
          wrapped_r <= 1'b1;
        end
      end
      case (state_r)
        IDLE: begin
          if (arm) begin
            wr_ptr_r   <= {AW{1'b0}};
            started_r  <= 1'b0;
            entries_r  <= {EW{1'b0}};
            wrapped_r  <= 1'b0;
            dump_req_r <= 1'b0;
            tracing_r  <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop) begin
            dump_req_r <= 1'b0;
            tracing_r  <= 1'b1;
            state_r    <= DRAIN;
          end else if (dump || full_hit_s) begin
            dump_req_r <= 1'b1;
            tracing_r  <= 1'b1;
            state_r    <= DRAIN;
          end
        end
        DRAIN: begin
          // A beat written in this cycle still counts toward a non-empty buffer.
          if (dump_req_r && ((entries_r != {EW{1'b0}}) || first_wr_s)) begin
            state_r <= READ;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        READ: begin
          if (!rd_valid_r) begin
            rd_addr_r  <= rd_start_s;
            rd_left_r  <= entries_r;
            rd_valid_r <= 1'b1;
            rd_last_r  <= (entries_r == EW'(1));
          end else if (rd_hs_s) begin
            rd_addr_r <= rd_addr_r + AW'(1);
            rd_left_r <= rd_left_r - EW'(1);
            if (rd_left_r == EW'(1)) begin
              rd_valid_r <= 1'b0;
              rd_last_r  <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end else begin
              rd_last_r <= (rd_left_r == EW'(2));
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          tracing_r  <= 1'b1;
          busy_r     <= 1'b0;
          rd_valid_r <= 1'b0;
          rd_last_r  <= 1'b0;
        end
      endcase
    end
  end

  delta_tb_ram #(
    .DEPTH (TB_SIZE),
    .WIDTH (VEC_W + 1),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_addr_s),
    .wdata ({comp_is_comp, comp_vector}),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  delta_tb_sequencer_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .beat    (beat_s),
    .inc     (comp_inc_ptr),
    .started (started_r)
  );

  // Payload is masked outside valid so idle and reset present all-zero rd_* outputs.
  assign rd.rd_valid  = rd_valid_r;
  assign rd.rd_last   = rd_last_r;
  assign rd.rd_comp   = rd_valid_r & ram_rdata_s[VEC_W];
  assign rd.rd_vector = rd_valid_r ? ram_rdata_s[VEC_W-1:0] : {VEC_W{1'b0}};
  assign comp_tracing = tracing_r;
  assign entries      = entries_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_delta_tb_sequencer.sv
// Directed bench for delta_tb_sequencer (TB_SIZE=4, N=2, DATA_WIDTH=8).
module tb_delta_tb_sequencer;

  localparam int VW = 16;
  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          rst, arm, stop, dump;
  logic          comp_valid, comp_is_comp, comp_inc_ptr;
  logic [VW-1:0] comp_vector;
  logic          comp_tracing, busy;
  logic [EW-1:0] entries;

  delta_tb_sequencer_if #(.VEC_W(VW)) rd_if ();

  delta_tb_sequencer #(.N(2), .DATA_WIDTH(8), .TB_SIZE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .stop         (stop),
    .dump         (dump),
    .comp_tracing (comp_tracing),
    .comp_valid   (comp_valid),
    .comp_vector  (comp_vector),
    .comp_is_comp (comp_is_comp),
    .comp_inc_ptr (comp_inc_ptr),
    .rd           (rd_if),
    .entries      (entries),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          arm, stop, dump, cv, inc, cmp;
    logic [VW-1:0] vec;
    logic          e_trc, e_val;
    logic [VW-1:0] e_vec;
    logic          e_cmp, e_last;
    logic [EW-1:0] e_ent;
    logic          e_busy;
  } row_t;

  row_t          tbl [11];
  logic [VW-1:0] vv [6];
  logic [VW-1:0] exp_vec [4];
  logic          exp_cmp [4];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [VW-1:0] v, input logic inc, input logic cmp);
    comp_valid = 1'b1; comp_vector = v; comp_inc_ptr = inc; comp_is_comp = cmp;
    step();
    comp_valid = 1'b0; comp_inc_ptr = 1'b0; comp_is_comp = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_dump();
    dump = 1'b1; step(); dump = 1'b0;
  endtask

  // Drain n entries against exp_vec/exp_cmp; stall 3 cycles on entry stall_k.
  task automatic read_expect(input int n, input int stall_k);
    int wait_cnt;
    rd_if.rd_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      wait_cnt = 0;
      while (!rd_if.rd_valid && wait_cnt < 20) begin
        step();
        wait_cnt++;
      end
      if (!rd_if.rd_valid) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_timeout: entry %0d never became valid", k);
        return;
      end
      check($sformatf("rd_vector[%0d]", k), rd_if.rd_vector, exp_vec[k]);
      check($sformatf("rd_comp[%0d]", k), rd_if.rd_comp, exp_cmp[k]);
      check($sformatf("rd_last[%0d]", k), rd_if.rd_last, (k == n - 1) ? 1 : 0);
      if (k == stall_k) begin
        for (int s = 0; s < 3; s++) begin
          step();
          check($sformatf("stall_valid[%0d]", s), rd_if.rd_valid, 1);
          check($sformatf("stall_vector[%0d]", s), rd_if.rd_vector, exp_vec[k]);
          check($sformatf("stall_comp[%0d]", s), rd_if.rd_comp, exp_cmp[k]);
          check($sformatf("stall_last[%0d]", s), rd_if.rd_last, (k == n - 1) ? 1 : 0);
        end
      end
      rd_if.rd_ready = 1'b1;
      step();
      rd_if.rd_ready = 1'b0;
    end
    check("read_done_valid", rd_if.rd_valid, 0);
    check("read_done_busy", busy, 0);
  endtask

  initial begin
    vv[0] = 16'h1100; vv[1] = 16'h2211; vv[2] = 16'h3322;
    vv[3] = 16'h4433; vv[4] = 16'h5544; vv[5] = 16'h6655;
    //          arm   stop  dump  cv    inc   cmp   vec     trc   val   e_vec   cmp   last  ent   busy
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, vv[0],  1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 3'd1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, vv[1],  1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 3'd1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, vv[2],  1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 3'd1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, vv[3],  1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 3'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, vv[4],  1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 3'd2, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0,  1'b0, 1'b0, 3'd2, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0,  1'b0, 1'b0, 3'd2, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, vv[3],  1'b1, 1'b0, 3'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, vv[4],  1'b0, 1'b1, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0,  1'b0, 1'b0, 3'd2, 1'b0};

    rst = 1'b1; arm = 1'b0; stop = 1'b0; dump = 1'b0;
    comp_valid = 1'b0; comp_is_comp = 1'b0; comp_inc_ptr = 1'b0; comp_vector = '0;
    rd_if.rd_ready = 1'b0;
    step(); step();
    check("reset_tracing", comp_tracing, 1);
    check("reset_busy", busy, 0);
    check("reset_entries", entries, 0);
    check("reset_rd_valid", rd_if.rd_valid, 0);
    check("reset_rd_last", rd_if.rd_last, 0);
    check("reset_rd_vector", rd_if.rd_vector, 0);
    rst = 1'b0;
    step();

    // Group fill in slot 0, one advance, dump, stream two entries.
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      arm = tbl[i].arm; stop = tbl[i].stop; dump = tbl[i].dump;
      comp_valid = tbl[i].cv; comp_inc_ptr = tbl[i].inc; comp_is_comp = tbl[i].cmp; comp_vector = tbl[i].vec;
      step();
      check($sformatf("row%0d_tracing", i), comp_tracing, tbl[i].e_trc);
      check($sformatf("row%0d_valid", i), rd_if.rd_valid, tbl[i].e_val);
      check($sformatf("row%0d_vector", i), rd_if.rd_vector, tbl[i].e_vec);
      check($sformatf("row%0d_comp", i), rd_if.rd_comp, tbl[i].e_cmp);
      check($sformatf("row%0d_last", i), rd_if.rd_last, tbl[i].e_last);
      check($sformatf("row%0d_entries", i), entries, tbl[i].e_ent);
      check($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
    end
    arm = 1'b0; dump = 1'b0; comp_valid = 1'b0; comp_inc_ptr = 1'b0; comp_is_comp = 1'b0;
    rd_if.rd_ready = 1'b0;

`ifdef DELTA_TB_STOP_ON_FULL_EN
    // Full buffer: fifth advance is dropped and readout starts on its own.
    pulse_arm();
    for (int k = 0; k < 5; k++) beat(vv[k], 1'b1, k[0]);
    check("full_drain_busy", busy, 1);
    check("full_drain_tracing", comp_tracing, 1);
    check("full_entries", entries, 4);
    for (int k = 0; k < 4; k++) begin exp_vec[k] = vv[k]; exp_cmp[k] = k[0]; end
    read_expect(4, 2);
`else
    // Wrap: six advances into four slots keep the newest four, oldest first.
    pulse_arm();
    for (int k = 0; k < 6; k++) beat(vv[k], 1'b1, k[0]);
    check("wrap_entries", entries, 4);
    pulse_dump();
    check("wrap_drain_tracing", comp_tracing, 1);
    for (int k = 0; k < 4; k++) begin exp_vec[k] = vv[k + 2]; exp_cmp[k] = k[0]; end
    read_expect(4, 1);
    check("wrap_entries_kept", entries, 4);
`endif

    // stop and dump together: stop wins, no readout.
    pulse_arm();
    beat(vv[0], 1'b1, 1'b0);
    stop = 1'b1; dump = 1'b1; step(); stop = 1'b0; dump = 1'b0;
    check("stopdump_drain_busy", busy, 1);
    check("stopdump_drain_tracing", comp_tracing, 1);
    step();
    check("stopdump_idle_busy", busy, 0);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stopdump_novalid%0d", s), rd_if.rd_valid, 0);
    end

    // dump with an empty buffer goes straight back to IDLE.
    pulse_arm();
    pulse_dump();
    check("empty_drain_busy", busy, 1);
    step();
    check("empty_idle_busy", busy, 0);
    check("empty_entries", entries, 0);
    step();
    check("empty_novalid", rd_if.rd_valid, 0);

    // A beat arriving in the DRAIN cycle is stored and read out.
    pulse_arm();
    beat(vv[0], 1'b1, 1'b1);
    pulse_dump();
    check("drainbeat_tracing", comp_tracing, 1);
    beat(vv[1], 1'b1, 1'b0);
    check("drainbeat_entries", entries, 2);
    exp_vec[0] = vv[0]; exp_cmp[0] = 1'b1;
    exp_vec[1] = vv[1]; exp_cmp[1] = 1'b0;
    read_expect(2, -1);

    // Reset in the middle of READ returns every output to its reset value.
    pulse_arm();
    beat(vv[2], 1'b1, 1'b0);
    beat(vv[3], 1'b1, 1'b1);
    pulse_dump();
    step(); step();
    check("rstread_valid_before", rd_if.rd_valid, 1);
    rst = 1'b1;
    step();
    check("rstread_valid", rd_if.rd_valid, 0);
    check("rstread_last", rd_if.rd_last, 0);
    check("rstread_vector", rd_if.rd_vector, 0);
    check("rstread_comp", rd_if.rd_comp, 0);
    check("rstread_tracing", comp_tracing, 1);
    check("rstread_busy", busy, 0);
    check("rstread_entries", entries, 0);
    rst = 1'b0;
    step();
    check("rstread_stays_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
